video_pixel_unpacker: RTL and testbench

//  Sequential, parametrised pixel unpacker between the video word FIFO and the palette/output stage.

---
 rtl/video_pixel_unpacker_pkg.sv | 36 +++
 rtl/video_pixel_select.sv | 45 ++++
 rtl/video_pixel_unpacker.sv | 162 ++++++++++++++++
 tb/tb_video_pixel_unpacker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pixel_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pixel_unpacker_pkg
// Description : Shared definitions for the video pixel unpacker: bits-per-pixel
//               codes, FSM state encoding and the bpp-code decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pixel_unpacker_pkg;

    // Bits-per-pixel codes as presented on cfg_bpp. The code value is also
    // log2 of the pixel width, which the datapath relies on for shifting.
    localparam logic [2:0] BPP_1  = 3'd0;
    localparam logic [2:0] BPP_2  = 3'd1;
    localparam logic [2:0] BPP_4  = 3'd2;
    localparam logic [2:0] BPP_8  = 3'd3;
    localparam logic [2:0] BPP_16 = 3'd4;
    localparam logic [2:0] BPP_32 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no active line
        ST_FETCH = 2'd1,   // hold register empty, waiting for a word
        ST_EMIT  = 2'd2    // hold register full, feeding the output slot
    } state_e;

    // Map a cfg_bpp code to log2(bpp). Codes wider than the word, and the
    // unused codes 6/7, fall back to 8bpp (always legal for WORD_W >= 16).
    function automatic logic [2:0] bpp_decode(input logic [2:0] code,
                                              input int         log2_word);
        if ((code > BPP_32) || (int'(code) > log2_word)) begin
            return BPP_8;
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_pixel_select.sv
`default_nettype none
// ============================================================================
// Module      : video_pixel_select
// Description : Combinational pixel extractor. Returns pixel idx of a packed
//               word (LSB-first), zero-extended to WORD_W.
// Ports       : word_i - packed word
//               idx_i  - pixel index within the word
//               lb_i   - log2(bits per pixel), already decoded to 0..5
//               pix_o  - selected pixel, zero-extended
// Revision    : 1.0 - initial release
// ============================================================================
module video_pixel_select
    import video_pixel_unpacker_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0]         word_i,
    input  logic [$clog2(WORD_W)-1:0] idx_i,
    input  logic [2:0]                lb_i,
    output logic [WORD_W-1:0]         pix_o
);
    localparam int IDX_W = $clog2(WORD_W);

    logic [IDX_W-1:0]  w_bitpos;
    logic [WORD_W-1:0] w_shifted;
    logic [WORD_W-1:0] w_mask;

    always_comb begin
        // idx < ppw guarantees idx*bpp < WORD_W, so the bit offset fits IDX_W.
        w_bitpos  = idx_i << lb_i;
        w_shifted = word_i >> w_bitpos;
        case (lb_i)
            BPP_1:   w_mask = WORD_W'(64'h1);
            BPP_2:   w_mask = WORD_W'(64'h3);
            BPP_4:   w_mask = WORD_W'(64'hF);
            BPP_8:   w_mask = WORD_W'(64'hFF);
            BPP_16:  w_mask = WORD_W'(64'hFFFF);
            BPP_32:  w_mask = WORD_W'(64'hFFFF_FFFF);
            default: w_mask = WORD_W'(64'hFF);
        endcase
        pix_o = w_shifted & w_mask;
    end

endmodule
`default_nettype wire

// File: rtl/video_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : video_pixel_unpacker
// Description : Unpacks WORD_W-bit packed pixel words into one pixel per clock
//               (LSB-first) with a per-line fine-scroll skip and pixel count.
// Ports       : clk, reset_n            - clock, async active-low reset
//               cfg_bpp, start_skip,
//               line_pixels, line_start - line config, sampled on line_start
//               in_word/in_valid/in_ready   - packed word input handshake
//               pix_out/pix_valid/pix_ready - pixel output handshake
//               pix_last                - last pixel of the line
//               line_done               - pulse after last pixel accepted
// Revision    : 1.0 - initial release
// ============================================================================
module video_pixel_unpacker
    import video_pixel_unpacker_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        cfg_bpp,
    input  logic              line_start,
    input  logic [5:0]        start_skip,
    input  logic [CNT_W-1:0]  line_pixels,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              line_done
);
    localparam int               IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_ONES = '1;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [2:0]        lb_q, lb_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WORD_W-1:0] pix_q, pix_d;
    logic              pv_q, pv_d;
    logic              pl_q, pl_d;
    logic              done_q, done_d;

    logic [2:0]        w_lb_new;
    logic [5:0]        w_skip;
    logic [IDX_W-1:0]  w_last_idx;
    logic              w_load;
    logic              w_word_end;
    logic              w_line_end;
    logic [WORD_W-1:0] w_sel;

    video_pixel_select #(
        .WORD_W (WORD_W)
    ) u_select (
        .word_i (hold_q),
        .idx_i  (idx_q),
        .lb_i   (lb_q),
        .pix_o  (w_sel)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        lb_d     = lb_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        pix_d    = pix_q;
        pv_d     = pv_q;
        pl_d     = pl_q;
        done_d   = 1'b0;

        w_lb_new   = bpp_decode(cfg_bpp, IDX_W);
        // ppw is a power of two, so "skip mod ppw" is a mask of ppw-1.
        w_skip     = start_skip & 6'(IDX_ONES >> w_lb_new);
        w_last_idx = IDX_ONES >> lb_q;

        w_load     = (state_q == ST_EMIT) && (!pv_q || pix_ready);
        w_word_end = (idx_q == w_last_idx);
        w_line_end = (rem_q == CNT_W'(1));

        // Refill in the same cycle the last pixel of a word moves to the
        // output slot, so the next word's pixel 0 loads on the following clock.
        in_ready = !line_start &&
                   ((state_q == ST_FETCH) ||
                    (w_load && w_word_end && !w_line_end));

        if (line_start) begin
            hold_d  = '0;
            pv_d    = 1'b0;
            pl_d    = 1'b0;
            lb_d    = w_lb_new;
            idx_d   = IDX_W'(w_skip);
            rem_d   = line_pixels;
            if (line_pixels == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            if (pv_q && pix_ready) begin
                pv_d   = 1'b0;
                pl_d   = 1'b0;
                done_d = pl_q;
            end
            if (w_load) begin
                pix_d = w_sel;
                pv_d  = 1'b1;
                pl_d  = w_line_end;
                rem_d = rem_q - CNT_W'(1);
                idx_d = w_word_end ? '0 : idx_q + IDX_W'(1);
                // Last pixel of the line: drop the rest of the word. The
                // output slot still holds pix_last until it is accepted.
                if (w_line_end) begin
                    state_d = ST_IDLE;
                end else if (w_word_end) begin
                    state_d = ST_FETCH;
                end
            end
            if (in_valid && in_ready) begin
                hold_d  = in_word;
                state_d = ST_EMIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            lb_q    <= BPP_8;
            idx_q   <= '0;
            rem_q   <= '0;
            pix_q   <= '0;
            pv_q    <= 1'b0;
            pl_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lb_q    <= lb_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            pix_q   <= pix_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            done_q  <= done_d;
        end
    end

    assign pix_out   = pix_q;
    assign pix_valid = pv_q;
    assign pix_last  = pl_q;
    assign line_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_pixel_unpacker
// Description : Directed self-checking bench for video_pixel_unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pixel_unpacker;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        cfg_bpp;
    logic              line_start;
    logic [5:0]        start_skip;
    logic [CNT_W-1:0]  line_pixels;
    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] pix_out;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              line_done;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] wq[$];
    logic [WORD_W:0]   got[$];
    logic [WORD_W:0]   expq[$];
    int                fa, la;

    video_pixel_unpacker #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_bpp     (cfg_bpp),
        .line_start  (line_start),
        .start_skip  (start_skip),
        .line_pixels (line_pixels),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_last    (pix_last),
        .line_done   (line_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic [WORD_W-1:0] p, input bit last);
        expq.push_back({last, p});
    endtask

    task automatic cmp(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s_pix%0d", tag, i), 64'(got[i]), 64'(expq[i]));
        got.delete();
        expq.delete();
    endtask

    // Pulse line_start for one cycle, then scramble cfg to show it is ignored mid-line.
    task automatic start_line(input logic [2:0] bpp, input logic [5:0] skip,
                              input logic [CNT_W-1:0] n);
        cfg_bpp     = bpp;
        start_skip  = skip;
        line_pixels = n;
        line_start  = 1'b1;
        @(posedge clk); #1;
        line_start  = 1'b0;
        cfg_bpp     = 3'd1;
        start_skip  = 6'd3;
        line_pixels = CNT_W'(7);
    endtask

    // Feed words from wq, collect accepted pixels into got. Bounded by max_cyc.
    task automatic run(input int max_cyc, input bit rnd, input bit expect_done,
                       output int first_acc, output int last_acc);
        int                cyc = 0;
        bit                done_seen = 1'b0;
        int                done_cyc = -1;
        bit                prev_stall = 1'b0;
        logic [WORD_W-1:0] prev_pix = '0;
        logic              prev_last = 1'b0;
        first_acc = -1;
        last_acc  = -1;
        while (cyc < max_cyc) begin
            in_valid  = (wq.size() > 0);
            in_word   = (wq.size() > 0) ? wq[0] : '0;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                chk("stall_pix", 64'(pix_out), 64'(prev_pix));
                chk("stall_valid", 64'(pix_valid), 64'd1);
                chk("stall_last", 64'(pix_last), 64'(prev_last));
            end
            if (line_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (in_valid && in_ready) void'(wq.pop_front());
            if (pix_valid && pix_ready) begin
                got.push_back({pix_last, pix_out});
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = pix_out;
            prev_last  = pix_last;
            if (done_seen) break;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        pix_ready = 1'b1;
        if (expect_done) begin
            chk("line_done_seen", 64'(done_seen), 64'd1);
            chk("line_done_lat", 64'(done_cyc), 64'(last_acc + 1));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_bpp     = 3'd3;
        line_start  = 1'b0;
        start_skip  = '0;
        line_pixels = '0;
        in_word     = '0;
        in_valid    = 1'b1;
        pix_ready   = 1'b1;
        #12;
        chk("rst_pix_out", 64'(pix_out), 64'd0);
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_pix_last", 64'(pix_last), 64'd0);
        chk("rst_line_done", 64'(line_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        // 1: 8bpp, two words, full rate
        start_line(3'd3, 6'd0, CNT_W'(8));
        wq = {32'h4433_2211, 32'h8877_6655};
        ex(32'h11, 0); ex(32'h22, 0); ex(32'h33, 0); ex(32'h44, 0);
        ex(32'h55, 0); ex(32'h66, 0); ex(32'h77, 0); ex(32'h88, 1);
        run(40, 1'b0, 1'b1, fa, la);
        cmp("t1");
        chk("t1_back_to_back", 64'(la - fa), 64'd7);
        in_valid = 1'b1;
        #1;
        chk("t1_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // 2: 1bpp, skip 5, 30 pixels spanning two words; third word untouched
        start_line(3'd0, 6'd5, CNT_W'(30));
        wq = {32'hFFFF_FFE0, 32'h0000_0005, 32'h1234_5678};
        for (int i = 0; i < 27; i++) ex(32'h1, 0);
        ex(32'h1, 0); ex(32'h0, 0); ex(32'h1, 1);
        run(80, 1'b0, 1'b1, fa, la);
        cmp("t2");
        chk("t2_word3_untaken", 64'(wq.size()), 64'd1);
        wq.delete();
        @(posedge clk); #1;

        // 3: 4bpp with random stalls
        start_line(3'd2, 6'd0, CNT_W'(16));
        wq = {32'h7654_3210, 32'hFEDC_BA98};
        for (int i = 0; i < 15; i++) ex(WORD_W'(i), 0);
        ex(32'hF, 1);
        run(300, 1'b1, 1'b1, fa, la);
        cmp("t3");
        @(posedge clk); #1;

        // 4: line_start mid-EMIT with a word offered in the same cycle
        start_line(3'd3, 6'd0, CNT_W'(8));
        wq = {32'h4433_2211, 32'h8877_6655};
        run(4, 1'b0, 1'b0, fa, la);
        wq.delete();
        got.delete();
        cfg_bpp     = 3'd4;
        start_skip  = 6'd0;
        line_pixels = CNT_W'(4);
        line_start  = 1'b1;
        in_valid    = 1'b1;
        in_word     = 32'h5555_6666;
        pix_ready   = 1'b1;
        #1;
        chk("t4_in_ready_ls", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        line_start = 1'b0;
        in_valid   = 1'b0;
        #1;
        chk("t4_pix_valid_cleared", 64'(pix_valid), 64'd0);
        chk("t4_pix_last_cleared", 64'(pix_last), 64'd0);
        wq = {32'h2222_1111, 32'h4444_3333};
        ex(32'h1111, 0); ex(32'h2222, 0); ex(32'h3333, 0); ex(32'h4444, 1);
        run(40, 1'b0, 1'b1, fa, la);
        cmp("t4");
        @(posedge clk); #1;

        // 5: empty line, then bpp code 7 (decodes to 8bpp) with skip 5 -> 1
        start_line(3'd3, 6'd0, CNT_W'(0));
        in_valid = 1'b1;
        #1;
        chk("t5_line_done", 64'(line_done), 64'd1);
        chk("t5_no_pix", 64'(pix_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("t5_line_done_pulse", 64'(line_done), 64'd0);
        in_valid = 1'b0;
        start_line(3'd7, 6'd5, CNT_W'(4));
        wq = {32'h4433_2211, 32'h8877_6655};
        ex(32'h22, 0); ex(32'h33, 0); ex(32'h44, 0); ex(32'h55, 1);
        run(40, 1'b0, 1'b1, fa, la);
        cmp("t5");
        wq.delete();
        @(posedge clk); #1;

        // 6: async reset mid-line
        start_line(3'd3, 6'd0, CNT_W'(8));
        wq = {32'h4433_2211, 32'h8877_6655};
        run(3, 1'b0, 1'b0, fa, la);
        chk("t6_pre_valid", 64'(pix_valid), 64'd1);
        wq.delete();
        got.delete();
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_pix_out", 64'(pix_out), 64'd0);
        chk("t6_rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("t6_rst_pix_last", 64'(pix_last), 64'd0);
        chk("t6_rst_line_done", 64'(line_done), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_idle_in_ready", 64'(in_ready), 64'd0);
            chk("t6_idle_pix_valid", 64'(pix_valid), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start_line(3'd3, 6'd0, CNT_W'(4));
        wq = {32'h0403_0201};
        ex(32'h01, 0); ex(32'h02, 0); ex(32'h03, 0); ex(32'h04, 1);
        run(40, 1'b0, 1'b1, fa, la);
        cmp("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
